// File: rtl/pattern_ram_mc_if.sv
// Host register port and playback stream bundle for pattern_ram_mc.
// The slave modport is the memory side; the master modport is the host/sink side.
interface pattern_ram_mc_if #(
   parameter int CH_NUM = 2,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic                     wr_en;
   logic [CH_W-1:0]          wr_ch;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     rd_en;
   logic [CH_W-1:0]          rd_ch;
   logic [ADDR_W-1:0]        rd_addr;
   logic [DATA_W-1:0]        rd_data;
   logic                     rd_valid;
   logic                     host_err;
   logic                     start;
   logic                     stop;
   logic [ADDR_W-1:0]        base_addr;
   logic [ADDR_W:0]          len;
   logic [CH_NUM*DATA_W-1:0] pb_data;
   logic                     pb_valid;
   logic                     pb_ready;
   logic                     busy;
   logic                     done;

   modport slave (
      input  wr_en, wr_ch, wr_addr, wr_data, rd_en, rd_ch, rd_addr,
      input  start, stop, base_addr, len, pb_ready,
      output rd_data, rd_valid, host_err, pb_data, pb_valid, busy, done
   );

   modport master (
      output wr_en, wr_ch, wr_addr, wr_data, rd_en, rd_ch, rd_addr,
      output start, stop, base_addr, len, pb_ready,
      input  rd_data, rd_valid, host_err, pb_data, pb_valid, busy, done
   );
endinterface

// File: rtl/pattern_ram_mc.sv
// Multi-channel pattern RAM with host port and lockstep playback engine.
// Optional PATTERN_RAM_LOOP_EN adds a 'loop' input for continuous playback.
//
// state | meaning
// IDLE  | host port open; waiting for start
// RUN   | streaming base..base+len-1 through the 2-entry skid buffer
// DONE  | last word accepted; done/busy-drop next cycle
module pattern_ram_mc #(
   parameter int CH_NUM = 2,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input logic clk,
   input logic rst,
`ifdef PATTERN_RAM_LOOP_EN
   input logic loop,
`endif
   pattern_ram_mc_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int LEN_W = ADDR_W + 1;
   localparam int PB_W  = CH_NUM * DATA_W;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;

   logic [DATA_W-1:0] mem [CH_NUM][DEPTH];

   logic [PB_W-1:0]   ram_q, buf0, buf1;
   logic              rd_pend;
   logic [1:0]        count;
   logic [ADDR_W-1:0] addr_r, base_r;
   logic [LEN_W-1:0]  len_r, remain_issue, remain_acc;
   logic              loop_r, loop_in;
   logic              busy_r, done_r, rd_valid_r, host_err_r;
   logic [DATA_W-1:0] rd_data_r;

`ifdef PATTERN_RAM_LOOP_EN
   assign loop_in = loop;
`else
   assign loop_in = 1'b0;
`endif

   logic              pb_valid_w, pop, start_go, run_issue, issue, room;
   logic              wr_ok, rd_ok, rd_conflict, host_err_w, loop_now;
   logic [2:0]        occ;
   logic [ADDR_W-1:0] rd_ptr, base_now;
   logic [LEN_W-1:0]  len_now, left;

   always_comb begin
      pb_valid_w  = (count != 2'd0);
      pop         = pb_valid_w & bus.pb_ready;
      // Occupancy after this edge; a read issued now lands one edge later.
      occ         = 3'(count) + 3'(rd_pend) - 3'(pop);
      room        = (occ <= 3'd1);
      start_go    = (state == IDLE) && bus.start && !bus.stop && (bus.len != '0);
      run_issue   = (state == RUN) && !bus.stop && room &&
                    ((remain_issue != '0) || loop_r);
      issue       = start_go | run_issue;
      rd_ptr      = (state == IDLE) ? bus.base_addr : addr_r;
      base_now    = (state == IDLE) ? bus.base_addr : base_r;
      len_now     = (state == IDLE) ? bus.len : len_r;
      loop_now    = (state == IDLE) ? loop_in : loop_r;
      left        = ((state == IDLE) ? bus.len : remain_issue) - LEN_W'(1);
      wr_ok       = bus.wr_en && !busy_r;
      rd_conflict = bus.rd_en && bus.wr_en && (bus.rd_ch == bus.wr_ch) &&
                    (bus.rd_addr != bus.wr_addr);
      rd_ok       = bus.rd_en && !busy_r && !rd_conflict;
      host_err_w  = (busy_r && (bus.rd_en || bus.wr_en)) ||
                    (!busy_r && rd_conflict);
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[bus.wr_ch][bus.wr_addr] <= bus.wr_data;
      if (issue)
         for (int c = 0; c < CH_NUM; c++)
            ram_q[c*DATA_W +: DATA_W] <= mem[c][rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         rd_valid_r   <= 1'b0;
         host_err_r   <= 1'b0;
         rd_data_r    <= '0;
         count        <= 2'd0;
         rd_pend      <= 1'b0;
         buf0         <= '0;
         buf1         <= '0;
         addr_r       <= '0;
         base_r       <= '0;
         len_r        <= '0;
         remain_issue <= '0;
         remain_acc   <= '0;
         loop_r       <= 1'b0;
      end else begin
         rd_valid_r <= rd_ok;
         host_err_r <= host_err_w;
         if (rd_ok)
            rd_data_r <= mem[bus.rd_ch][bus.rd_addr];
         done_r  <= 1'b0;
         rd_pend <= issue;

         if (issue) begin
            if ((left == '0) && loop_now) begin
               addr_r       <= base_now;
               remain_issue <= len_now;
            end else begin
               addr_r       <= rd_ptr + ADDR_W'(1);
               remain_issue <= left;
            end
         end

         // Head slot only moves on a pop, so pb_data holds steady while stalled.
         case ({rd_pend, pop})
            2'b10: begin
               if (count == 2'd0) buf0 <= ram_q;
               else               buf1 <= ram_q;
               count <= count + 2'd1;
            end
            2'b01: begin
               buf0  <= buf1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) buf0 <= ram_q;
               else begin
                  buf0 <= buf1;
                  buf1 <= ram_q;
               end
            end
            default: ;
         endcase

         if (pop)
            remain_acc <= remain_acc - LEN_W'(1);

         case (state)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  if (bus.len == '0)
                     done_r <= 1'b1;
                  else begin
                     state      <= RUN;
                     busy_r     <= 1'b1;
                     base_r     <= bus.base_addr;
                     len_r      <= bus.len;
                     loop_r     <= loop_in;
                     remain_acc <= bus.len;
                  end
               end
            end
            RUN: begin
               if (pop && (remain_acc == LEN_W'(1)) && !loop_r)
                  state <= DONE;
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
            default: state <= IDLE;
         endcase

         if (bus.stop && (state != IDLE)) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            count   <= 2'd0;
            rd_pend <= 1'b0;
         end
      end
   end

   assign bus.rd_data  = rd_data_r;
   assign bus.rd_valid = rd_valid_r;
   assign bus.host_err = host_err_r;
   assign bus.pb_data  = buf0;
   assign bus.pb_valid = pb_valid_w;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
endmodule
